// File: rtl/fp_pkg.sv
// Shared types and constants for the floating-point divider front end.
package fp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  localparam logic [63:0] FP64_QNAN = 64'h7FF8_0000_0000_0000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after prio, wrapping.
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] prio,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_idx,
  output logic            any
);

  always_comb begin
    int unsigned idx;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(prio) + i) % N;
      if (!any && req[idx]) begin
        any          = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/fp_div_arbiter.sv
// Shares one multi-cycle fp64 divider among N_REQ requesters, one operation at a time,
// with a watchdog that abandons a stuck divide and returns a tagged qNaN error response.
module fp_div_arbiter
  import fp_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 255,
  localparam int unsigned ID_W   = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*64-1:0]   req_a,
  input  logic [N_REQ*64-1:0]   req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [63:0]           rsp_data,
  output logic                  rsp_err,
  output logic                  div_start,
  output logic [63:0]           div_a,
  output logic [63:0]           div_b,
  input  logic                  div_done,
  input  logic [63:0]           div_res,
  output logic                  div_flush,
  output logic                  busy
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   prio_q, prio_d;
  logic [63:0]       div_a_q, div_a_d, div_b_q, div_b_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [63:0]       rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]  wdog_q, wdog_d;
  logic              flush_q, flush_d;

  logic [N_REQ-1:0]  gnt;
  logic [ID_W-1:0]   gnt_idx;
  logic              gnt_any;

  rr_arbiter #(
    .N (N_REQ)
  ) u_rr_arbiter (
    .req     (req_valid),
    .prio    (prio_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    div_a_d    = div_a_q;
    div_b_d    = div_b_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    wdog_d     = wdog_q;
    flush_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_any) begin
          state_d  = ISSUE;
          div_a_d  = req_a[{gnt_idx, 6'd0} +: 64];
          div_b_d  = req_b[{gnt_idx, 6'd0} +: 64];
          rsp_id_d = gnt_idx;
          prio_d   = (32'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + ID_W'(1);
        end
      end
      ISSUE: begin
        wdog_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wdog_d = wdog_q + CNT_W'(1);
        // A completion in the last watchdog cycle still wins over the timeout.
        if (div_done) begin
          rsp_data_d = div_res;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end else if (wdog_q == CNT_W'(TIMEOUT - 1)) begin
          rsp_data_d = FP64_QNAN;
          rsp_err_d  = 1'b1;
          flush_d    = 1'b1;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      prio_q     <= '0;
      div_a_q    <= '0;
      div_b_q    <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      wdog_q     <= '0;
      flush_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      div_a_q    <= div_a_d;
      div_b_q    <= div_b_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      wdog_q     <= wdog_d;
      flush_q    <= flush_d;
    end
  end

  assign req_ready = (state_q == IDLE) ? gnt : '0;
  assign rsp_valid = (state_q == RESP);
  assign div_start = (state_q == ISSUE);
  assign busy      = (state_q != IDLE);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign div_a     = div_a_q;
  assign div_b     = div_b_q;
  assign div_flush = flush_q;

endmodule

// File: doc/fp_div_arbiter.md
# fp_div_arbiter

Round-robin arbiter and sequencer that shares one multi-cycle double-precision divider (`fp_div` datapath) among `N_REQ` requesters. It sits between the calculator's issue ports and the divider. It accepts one division at a time over a valid/ready handshake, pulses the divider's start, and waits for completion with a watchdog. It returns the quotient on a shared response bus tagged with the requester index.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, ≥2; `ID_W = $clog2(N_REQ)`.
- `TIMEOUT`, 255: maximum cycles spent in WAIT before the operation is abandoned, ≥1.

Ports:
- `clk`  in  1  clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-high.
- `req_valid`  in  N_REQ  per-requester request valid.
- `req_ready`  out  N_REQ  one-hot accept; at most one bit is high.
- `req_a`  in  N_REQ*64  dividend for requester i, in bits `[64*i +: 64]`.
- `req_b`  in  N_REQ*64  divisor for requester i, same packing.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumer ready.
- `rsp_id`  out  ID_W  index of the requester that owns the response.
- `rsp_data`  out  64  quotient, IEEE 754 binary64.
- `rsp_err`  out  1  high when the watchdog expired; `rsp_data` is then qNaN.
- `div_start`  out  1  one-cycle start pulse to the divider.
- `div_a`, `div_b`  out  64 each  operands to the divider; held stable from ISSUE through WAIT.
- `div_done`  in  1  divider completion pulse.
- `div_res`  in  64  divider result, valid while `div_done` is high.
- `div_flush`  out  1  one-cycle synchronous clear to the divider, issued on timeout.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states and transitions:
  - IDLE: transitions to ISSUE when any request is valid.
  - ISSUE: always transitions to WAIT.
  - WAIT: transitions to RESP on `div_done`, or on timeout.
  - RESP: transitions to IDLE on `rsp_ready`.
- IDLE:
  - Round-robin search starts at `prio` and wraps modulo N_REQ.
  - The first requester with `req_valid` set becomes the grant `g`.
  - `req_ready[g]` is driven combinationally high.
  - At the clock edge: latch `req_a[g]` and `req_b[g]` into `div_a`/`div_b`, latch `g` into `rsp_id`, and set `prio <= (g+1) mod N_REQ`.
  - With no request valid, `req_ready` is 0 and `prio` is unchanged.
- ISSUE:
  - `div_start=1` for exactly this cycle.
  - Clear the watchdog counter.
- WAIT:
  - The watchdog counter increments every cycle.
  - If `div_done` is high: latch `div_res` into `rsp_data`, set `rsp_err=0`, go to RESP. `div_done` takes priority over timeout in the same cycle.
  - Else if the counter equals TIMEOUT-1: set `rsp_data = 64'h7FF8_0000_0000_0000`, set `rsp_err=1`, pulse `div_flush` on the next cycle, go to RESP.
- RESP:
  - `rsp_valid=1`; `rsp_data`, `rsp_id` and `rsp_err` are held stable.
  - On `rsp_valid && rsp_ready`, go to IDLE.
- `div_done` is sampled only in WAIT. A pulse in any other state is ignored, including a late pulse from an abandoned operation that arrives before `div_flush` takes effect.
- `req_ready` is 0 in every state except IDLE, so no request is accepted while an operation is in flight.
- A requester that deasserts `req_valid` before it is granted loses nothing and keeps no reservation.

## Timing
- Reset values:
  - FSM state is IDLE and `prio` is 0.
  - `req_ready`, `rsp_valid`, `rsp_id`, `rsp_data`, `rsp_err`, `div_start`, `div_a`, `div_b`, `div_flush` and `busy` are all 0.
- Reset asserted mid-operation aborts immediately. No response is produced, and the divider is expected to share the same reset.
- Latency, with the handshake accepted in cycle 0:
  - `div_start` is high in cycle 1.
  - `div_done` is earliest in cycle 2.
  - `rsp_valid` rises the cycle after `div_done` is seen.
  - With a divider latency of D cycles (start to done), `rsp_valid` rises in cycle 2+D.
- A new request can be accepted in the cycle after the response handshake.
- The minimum issue interval is D+3 cycles, assuming `rsp_ready` is held high.
- Timeout: the first WAIT cycle is cycle 2. If no `div_done` arrives, RESP starts in cycle 2+TIMEOUT and `div_flush` is high in that same cycle.

## Structure
- Shared package `fp_pkg` holds:
  - the FSM state enum (`IDLE`, `ISSUE`, `WAIT`, `RESP`);
  - constant `FP64_QNAN = 64'h7FF8_0000_0000_0000`.
- One sub-module, `rr_arbiter`:
  - parameter `N`;
  - inputs `req[N]` and `prio[ID_W]`;
  - outputs `gnt` (one-hot), `gnt_idx` and `any`.
  - It is purely combinational; `prio` is registered in `fp_div_arbiter`.

## Test plan
- Single request: requester 2 sends a=3.0 (`4008000000000000`) and b=2.0; the divider model has D=5 → `rsp_valid` in cycle 7, `rsp_id=2`, `rsp_data=3FF8000000000000`, `rsp_err=0`.
- Fairness: all four requesters hold `req_valid` continuously → grants go 0,1,2,3,0, each requester receives exactly one response per round, and there is never more than one `req_ready` bit high.
- Backpressure: `rsp_ready=0` for 10 cycles after `rsp_valid` → `rsp_data` and `rsp_id` stay stable, `req_ready` stays 0, and the next grant comes only after the handshake.
- Timeout: with TIMEOUT=8 the divider never asserts done → RESP starts in cycle 10 with `rsp_err=1` and `rsp_data=7FF8000000000000`; a 1-cycle `div_flush` is issued and a stray `div_done` in RESP is ignored.
- Done/timeout collision: `div_done` arrives in the final timeout cycle → the result is delivered with `rsp_err=0` and no `div_flush`.
- Reset in WAIT: `reset` is pulsed mid-operation → all outputs go to 0, `prio` goes to 0, no response is produced, and the next request to arrive is served normally.
